// File: rtl/mul32_seq_pkg.sv
// Shared constants and types for the sequential 32x32 multiplier.
// MUL32_SEQ_HIGH_EN selects the full 64-bit product (adds step S3 and result_hi).
package mcu_pkg;

   localparam int unsigned HW = 16;

`ifdef MUL32_SEQ_HIGH_EN
   localparam int unsigned STEPS = 4;
   localparam int unsigned ACC_W = 64;
`else
   localparam int unsigned STEPS = 3;
   localparam int unsigned ACC_W = 32;
`endif

   typedef enum logic [3:0] {
      IDLE,
      S0,
      S1,
      S2,
      S3,
      WAIT0,
      WAIT1,
      WAIT2,
      WAIT3,
      FIN
   } state_t;

   // Encoded so that {sh, 4'b0} is the shift amount (0/16/32).
   typedef enum logic [1:0] {
      SH0  = 2'd0,
      SH16 = 2'd1,
      SH32 = 2'd2
   } shift_t;

endpackage

// File: rtl/mul32_acc.sv
// Partial-product accumulator: acc <= (clr ? 0 : acc) + (p << shift) when en.
// The pre-register sum is exported so the parent can register the final result in the same edge.
module mul32_acc
   import mcu_pkg::*;
#(
   parameter int unsigned W = ACC_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   input  shift_t       sh,
   input  logic [31:0]  p,
   output logic [W-1:0] sum
);

   logic [W-1:0] acc;
   logic [W-1:0] base;
   logic [W-1:0] pext;
   logic [5:0]   shamt;

   always_comb begin
      base  = clr ? '0 : acc;
      pext  = W'(p);
      shamt = {sh, 4'b0000};
      sum   = base + (pext << shamt);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         acc <= '0;
      else if (en)
         acc <= sum;
   end

endmodule

// File: rtl/mul32_seq.sv
// Unsigned 32x32 multiply sequenced over a shared external 16x16 multiplier.
// MUL32_SEQ_HIGH_EN: produce all 64 product bits (result_hi port, S3/WAIT3 steps).
module mul32_seq
   import mcu_pkg::*;
#(
   parameter int unsigned MUL_LAT = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [31:0]   a,
   input  logic [31:0]   b,
   output logic          busy,
   output logic          done,
   output logic [31:0]   result_lo,
`ifdef MUL32_SEQ_HIGH_EN
   output logic [31:0]   result_hi,
`endif
   output logic [HW-1:0] mul_a,
   output logic [HW-1:0] mul_b,
   input  logic [31:0]   mul_p
);

   localparam bit REG_IP = (MUL_LAT != 0);

`ifdef MUL32_SEQ_HIGH_EN
   localparam state_t AFTER_S2 = S3;
`else
   localparam state_t AFTER_S2 = FIN;
`endif

   state_t           state;
   state_t           state_nx;
   logic [31:0]      a_q;
   logic [31:0]      b_q;
   logic [1:0]       step;
   logic             in_step;
   logic             in_wait;
   logic             cap;
   logic             clr;
   logic             last;
   logic             accept;
   shift_t           sh;
   logic [ACC_W-1:0] sum;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = S0;
         S0:      state_nx = REG_IP ? WAIT0 : S1;
         WAIT0:   state_nx = S1;
         S1:      state_nx = REG_IP ? WAIT1 : S2;
         WAIT1:   state_nx = S2;
         S2:      state_nx = REG_IP ? WAIT2 : AFTER_S2;
         WAIT2:   state_nx = AFTER_S2;
`ifdef MUL32_SEQ_HIGH_EN
         S3:      state_nx = REG_IP ? WAIT3 : FIN;
         WAIT3:   state_nx = FIN;
`endif
         FIN:     state_nx = start ? S0 : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_step = 1'b0;
      in_wait = 1'b0;
      step    = 2'd0;
      done    = 1'b0;
      unique case (state)
         S0:      begin in_step = 1'b1; step = 2'd0; end
         S1:      begin in_step = 1'b1; step = 2'd1; end
         S2:      begin in_step = 1'b1; step = 2'd2; end
         S3:      begin in_step = 1'b1; step = 2'd3; end
         WAIT0:   begin in_wait = 1'b1; step = 2'd0; end
         WAIT1:   begin in_wait = 1'b1; step = 2'd1; end
         WAIT2:   begin in_wait = 1'b1; step = 2'd2; end
         WAIT3:   begin in_wait = 1'b1; step = 2'd3; end
         FIN:     done = 1'b1;
         default: ;
      endcase
      busy   = in_step | in_wait;
      cap    = REG_IP ? in_wait : in_step;
      clr    = (step == 2'd0);
      last   = cap && (step == 2'(STEPS - 1));
      accept = start && ((state == IDLE) || (state == FIN));
      sh     = (step == 2'd0) ? SH0 : ((step == 2'd3) ? SH32 : SH16);
      // step[1] picks the high half of a, step[0] the high half of b.
      mul_a  = '0;
      mul_b  = '0;
      if (busy) begin
         mul_a = step[1] ? a_q[2*HW-1:HW] : a_q[HW-1:0];
         mul_b = step[0] ? b_q[2*HW-1:HW] : b_q[HW-1:0];
      end
   end

   mul32_acc #(.W(ACC_W)) u_acc (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .en    (cap),
      .sh    (sh),
      .p     (mul_p),
      .sum   (sum)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q       <= '0;
         b_q       <= '0;
         result_lo <= '0;
`ifdef MUL32_SEQ_HIGH_EN
         result_hi <= '0;
`endif
      end else begin
         if (accept) begin
            a_q <= a;
            b_q <= b;
         end
         if (last) begin
            result_lo <= sum[31:0];
`ifdef MUL32_SEQ_HIGH_EN
            result_hi <= sum[63:32];
`endif
         end
      end
   end

endmodule

// File: tb/tb_mul32_seq.sv
// Bench for mul32_seq: one instance per multiplier latency, each with a behavioural 16x16 IP.
// Honours MUL32_SEQ_HIGH_EN for step count and result_hi.
module tb_mul32_seq;

`ifdef MUL32_SEQ_HIGH_EN
   localparam int NSTEP = 4;
`else
   localparam int NSTEP = 3;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start [2];
   logic [31:0] a [2];
   logic [31:0] b [2];
   logic        busy [2];
   logic        done [2];
   logic [31:0] rlo [2];
`ifdef MUL32_SEQ_HIGH_EN
   logic [31:0] rhi [2];
`endif
   logic [15:0] ma [2];
   logic [15:0] mb [2];
   logic [31:0] mp0;
   logic [31:0] mp1;
   logic [31:0] last_lo [2];
   logic [31:0] last_hi [2];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   // Shared multiplier IP models: combinational and one-cycle registered.
   assign mp0 = {16'b0, ma[0]} * {16'b0, mb[0]};
   always @(posedge clk) mp1 <= {16'b0, ma[1]} * {16'b0, mb[1]};

   mul32_seq #(.MUL_LAT(0)) dut0 (
      .clk       (clk),
      .reset     (reset),
      .start     (start[0]),
      .a         (a[0]),
      .b         (b[0]),
      .busy      (busy[0]),
      .done      (done[0]),
      .result_lo (rlo[0]),
`ifdef MUL32_SEQ_HIGH_EN
      .result_hi (rhi[0]),
`endif
      .mul_a     (ma[0]),
      .mul_b     (mb[0]),
      .mul_p     (mp0)
   );

   mul32_seq #(.MUL_LAT(1)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .start     (start[1]),
      .a         (a[1]),
      .b         (b[1]),
      .busy      (busy[1]),
      .done      (done[1]),
      .result_lo (rlo[1]),
`ifdef MUL32_SEQ_HIGH_EN
      .result_hi (rhi[1]),
`endif
      .mul_a     (ma[1]),
      .mul_b     (mb[1]),
      .mul_p     (mp1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_idle_zero(input int k, input string tag);
      check({tag, " busy"},  64'(busy[k]), 64'd0);
      check({tag, " done"},  64'(done[k]), 64'd0);
      check({tag, " lo"},    64'(rlo[k]),  64'd0);
`ifdef MUL32_SEQ_HIGH_EN
      check({tag, " hi"},    64'(rhi[k]),  64'd0);
`endif
      check({tag, " mul_a"}, 64'(ma[k]),   64'd0);
      check({tag, " mul_b"}, 64'(mb[k]),   64'd0);
   endtask

   // Follows one multiply from the cycle after start is sampled; c counts cycles from t0.
   task automatic track(input int k, input logic [31:0] av, input logic [31:0] bv,
                        input bit poke, input bit chain,
                        input logic [31:0] cav, input logic [31:0] cbv);
      int          lat    = k;
      int          bc     = NSTEP * (1 + lat);
      int          last_c = chain ? bc + 1 : bc + 2;
      int          ndone  = 0;
      int          st;
      logic [63:0] prod   = 64'(av) * 64'(bv);
      logic [15:0] ea;
      logic [15:0] eb;
      string       t;
      for (int c = 1; c <= last_c; c++) begin
         @(negedge clk);
         t = $sformatf("k%0d c%0d a=%h b=%h", k, c, av, bv);
         if (done[k]) ndone++;
         check({t, " busy"}, 64'(busy[k]), 64'(c <= bc));
         check({t, " done"}, 64'(done[k]), 64'(c == bc + 1));
         if (c <= bc) begin
            st = (c - 1) / (1 + lat);
            ea = (st < 2) ? av[15:0] : av[31:16];
            eb = (st == 0 || st == 2) ? bv[15:0] : bv[31:16];
         end else begin
            ea = '0;
            eb = '0;
         end
         check({t, " mul_a"}, 64'(ma[k]), 64'(ea));
         check({t, " mul_b"}, 64'(mb[k]), 64'(eb));
         if (c <= bc) begin
            check({t, " lo held"}, 64'(rlo[k]), 64'(last_lo[k]));
`ifdef MUL32_SEQ_HIGH_EN
            check({t, " hi held"}, 64'(rhi[k]), 64'(last_hi[k]));
`endif
         end else begin
            check({t, " lo"}, 64'(rlo[k]), 64'(prod[31:0]));
`ifdef MUL32_SEQ_HIGH_EN
            check({t, " hi"}, 64'(rhi[k]), 64'(prod[63:32]));
`endif
         end
         if (c == bc + 1) begin
            last_lo[k] = prod[31:0];
            last_hi[k] = prod[63:32];
         end
         start[k] = 1'b0;
         if (poke && c == 2 + lat) begin
            start[k] = 1'b1;
            a[k]     = ~av;
            b[k]     = bv + 32'd7;
         end
         if (chain && c == bc + 1) begin
            start[k] = 1'b1;
            a[k]     = cav;
            b[k]     = cbv;
         end
      end
      check($sformatf("k%0d a=%h b=%h done count", k, av, bv), 64'(ndone), 64'd1);
   endtask

   task automatic run_mul(input int k, input logic [31:0] av, input logic [31:0] bv, input bit poke);
      @(negedge clk);
      start[k] = 1'b1;
      a[k]     = av;
      b[k]     = bv;
      track(k, av, bv, poke, 1'b0, '0, '0);
   endtask

   task automatic run_chain(input int k, input logic [31:0] av, input logic [31:0] bv,
                            input logic [31:0] cav, input logic [31:0] cbv);
      @(negedge clk);
      start[k] = 1'b1;
      a[k]     = av;
      b[k]     = bv;
      track(k, av, bv, 1'b0, 1'b1, cav, cbv);
      track(k, cav, cbv, 1'b0, 1'b0, '0, '0);
   endtask

   // Starts a=b=0x10000 and asserts reset asynchronously during S2.
   task automatic reset_mid(input int k);
      @(negedge clk);
      start[k] = 1'b1;
      a[k]     = 32'h0001_0000;
      b[k]     = 32'h0001_0000;
      for (int c = 1; c <= 2 * (1 + k) + 1; c++) begin
         @(negedge clk);
         start[k] = 1'b0;
      end
      check($sformatf("k%0d busy before reset", k), 64'(busy[k]), 64'd1);
      check($sformatf("k%0d mul_a in S2", k), 64'(ma[k]), 64'd1);
      #2 reset = 1'b1;
      #1 check_idle_zero(k, $sformatf("k%0d mid-reset", k));
      #1 reset = 1'b0;
      for (int j = 0; j < 2; j++) begin
         last_lo[j] = '0;
         last_hi[j] = '0;
      end
   endtask

   initial begin
      reset = 1'b1;
      for (int j = 0; j < 2; j++) begin
         start[j]   = 1'b0;
         a[j]       = '0;
         b[j]       = '0;
         last_lo[j] = '0;
         last_hi[j] = '0;
      end
      repeat (2) @(negedge clk);
      for (int j = 0; j < 2; j++) check_idle_zero(j, $sformatf("k%0d reset", j));
      reset = 1'b0;

      for (int k = 0; k < 2; k++) begin
         run_mul(k, 32'd3, 32'd5, 1'b0);
         run_mul(k, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
         run_mul(k, 32'h8000_0000, 32'd2, 1'b0);
         run_mul(k, 32'd0, 32'h1234_5678, 1'b0);
         run_mul(k, $urandom, $urandom, 1'b1);
         run_chain(k, $urandom, $urandom, $urandom, $urandom);
         reset_mid(k);
         run_mul(k, 32'h0001_0000, 32'h0001_0000, 1'b0);
         for (int i = 0; i < 6; i++) run_mul(k, $urandom, $urandom, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
